config_sequencer: RTL
=====================

# config_sequencer

Configuration loader for the tile array. Accepts a stream of (address, data) configuration words over a valid/ready handshake and broadcasts each word on the shared `config_addr`/`config_data` bus, holding it long enough for every tile's address matcher and configuration registers to capture it. Between words it parks the bus on a reserved idle address that no tile matches. It sits between the off-fabric bitstream source and the array's configuration inputs.

## Interface
- `HOLD_CYCLES`, 2: cycles each word is held on the bus; legal range 1..15.
- `IDLE_ADDR`, 32'hFFFF_FFFF: address driven whenever no word is being written; reserved and never matched by any tile.
- `clk` input 1: single clock; all state is updated on its rising edge.
- `reset` input 1: synchronous, active-low reset, sampled on `clk`.
- `start` input 1: begins a load when sampled high in IDLE; ignored in every other state.
- `abort` input 1: abandons the load in progress.
- `in_valid` input 1: the stream word is valid.
- `in_ready` output 1: the sequencer accepts the word this cycle.
- `in_addr` input 32: configuration address (bits [15:0] tile id, bits [31:16] module id).
- `in_data` input 32: configuration data.
- `in_last` input 1: marks the final word of the load.
- `config_addr` output 32: broadcast configuration address.
- `config_data` output 32: broadcast configuration data.
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: one-cycle pulse when a load completes normally.
- `error` output 1: sticky flag; set when a received word carries `IDLE_ADDR`.
- `word_count` output 16: number of words driven in the current or last load; saturates at 16'hFFFF.
- `checksum` output 32: running checksum (see Configuration).

## Operation
- States: IDLE, FETCH, DRIVE, GAP, DONE.
- IDLE
  - `start`=1 → FETCH.
  - Clears `word_count`, `checksum` and `error`.
- FETCH
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: capture addr, data and last, then go to DRIVE.
  - A captured word whose address equals `IDLE_ADDR` is discarded: `error` is set and the FSM stays in FETCH.
  - A discarded word that also carries `in_last`=1 goes to DONE.
- DRIVE
  - `config_addr`/`config_data` = the captured word for exactly `HOLD_CYCLES` cycles (hold counter 4 bits).
  - `word_count` increments once, on entry.
  - Then → GAP.
- GAP
  - Drives exactly one cycle of `config_addr`=`IDLE_ADDR`; `config_data` keeps its last value.
  - Then → DONE if the captured last flag is set, otherwise → FETCH.
- DONE
  - `done`=1 for one cycle.
  - Then → IDLE.
- `abort`=1 in FETCH, DRIVE or GAP
  - Next cycle: IDLE with `config_addr`=`IDLE_ADDR`.
  - `done` is not pulsed.
  - `word_count` keeps its value.
  - Abort has priority over every other transition.
- `abort` in IDLE or DONE is ignored.
- `in_ready` is 0 in every state except FETCH.

## Timing
- All outputs are registered.
- Reset values:
  - FSM = IDLE.
  - `config_addr`=`IDLE_ADDR`, `config_data`=0.
  - `in_ready`=0, `busy`=0, `done`=0, `error`=0.
  - `word_count`=0, `checksum`=0.
- Latency:
  - `start` at cycle t → `in_ready`=1 at t+1.
  - Handshake at cycle h → word on the bus for cycles h+1..h+`HOLD_CYCLES`.
  - GAP at h+`HOLD_CYCLES`+1.
  - Next FETCH at h+`HOLD_CYCLES`+2.
- Throughput: one word per `HOLD_CYCLES`+2 cycles.
- Reset asserted mid-load: the bus returns to `IDLE_ADDR` on the next edge. Tiles may hold partial configuration; software must reload.
- `start` and `abort` in the same cycle in IDLE: `start` wins, because `abort` is ignored in IDLE.

## Configuration
- `CONFIG_SEQ_CHECKSUM_EN` defined:
  - `checksum` accumulates `checksum ^ (addr ^ data)` for each word it drives, updated on DRIVE entry.
  - Discarded words do not contribute.
- Macro undefined:
  - `checksum` is tied to 0.
  - No accumulator register is built.

## Structure
- Shared package `config_seq_pkg` holds:
  - the FSM state enum,
  - the `IDLE_ADDR` default constant,
  - the tile-id and module-id field bounds (15:0, 31:16).
- Sub-module `config_hold_timer`: a loadable 4-bit down-counter that produces an expiry pulse for DRIVE. Everything else stays in the top module.

## Test plan
- Single word, `HOLD_CYCLES`=2: (32'h0001_0003, 32'h5) with `in_last`=1 → bus shows the word for 2 cycles, then `IDLE_ADDR` for 1 cycle, then `done` pulses; `word_count`=1.
- Three back-to-back words with `in_valid` held high → handshakes are exactly 4 cycles apart; `word_count`=3; with the macro defined, `checksum` = XOR of all six fields.
- Word with addr=32'hFFFF_FFFF, followed by a good word with `in_last`=1 → `error`=1 and stays set until the next `start`; only the good word is driven; `word_count`=1.
- `abort` on the second DRIVE cycle of word 2 of 4 → next cycle `config_addr`=`IDLE_ADDR` and `busy`=0; no `done` pulse; `word_count`=2.
- `reset`=0 asserted during GAP → next edge gives every output at its reset value; a new `start` then loads normally.
- `in_valid` held low for 10 cycles in FETCH → `in_ready` stays 1 and the bus stays at `IDLE_ADDR`, with no change in `word_count`.

Source files
------------

// File: rtl/config_seq_pkg.sv
// ----------------------------------------------------------------------------
// config_seq_pkg
// Shared definitions for the configuration sequencer:
//   - seqState_e          : sequencer FSM state encoding
//   - IDLE_ADDR_DEFAULT   : reserved bus address that no tile ever matches
//   - TILE_ID_* / MODULE_ID_* : bit bounds of the fields inside a config address
//   - HOLD_CNT_W          : width of the per-word hold counter
// ----------------------------------------------------------------------------
package config_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_DRIVE = 3'd2,
      ST_GAP   = 3'd3,
      ST_DONE  = 3'd4
   } seqState_e;

   localparam logic [31:0] IDLE_ADDR_DEFAULT = 32'hFFFF_FFFF;

   localparam int TILE_ID_LSB   = 0;
   localparam int TILE_ID_MSB   = 15;
   localparam int MODULE_ID_LSB = 16;
   localparam int MODULE_ID_MSB = 31;

   localparam int HOLD_CNT_W = 4;

endpackage

// File: rtl/config_hold_timer.sv
// ----------------------------------------------------------------------------
// config_hold_timer
// Loadable down-counter that times how long a configuration word stays on the
// broadcast bus. Loading N makes expire_o high during the Nth cycle after the
// load, which is the last cycle the word should be held.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous active-low reset
//   load_i       in   load loadValue_i into the counter
//   clear_i      in   force the counter to zero (abandoned word)
//   loadValue_i  in   hold length in cycles (1..15)
//   expire_o     out  high during the final hold cycle
// ----------------------------------------------------------------------------
module config_hold_timer
   import config_seq_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load_i,
   input  logic                  clear_i,
   input  logic [HOLD_CNT_W-1:0] loadValue_i,
   output logic                  expire_o
);

   logic [HOLD_CNT_W-1:0] count_q;
   logic [HOLD_CNT_W-1:0] count_d;

   // Counter next-state: clear wins over load, and the counter rests at zero
   // once it has run down so it never wraps into a spurious expiry.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (load_i) begin
         count_d = loadValue_i;
      end else if (count_q != '0) begin
         count_d = count_q - HOLD_CNT_W'(1);
      end
   end

   // Counter register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // A count of one means this is the last cycle of the hold window.
   assign expire_o = (count_q == HOLD_CNT_W'(1));

endmodule

// File: rtl/config_sequencer.sv
// ----------------------------------------------------------------------------
// config_sequencer
// Loads the tile array configuration: accepts (address, data) words over a
// valid/ready stream and broadcasts each one on config_addr/config_data for
// HOLD_CYCLES cycles, followed by one cycle of the reserved idle address so
// tiles see a clean boundary between words.
//
// Optional feature: define CONFIG_SEQ_CHECKSUM_EN to build a running XOR
// checksum of every driven word; otherwise checksum is tied to zero.
//
// Parameters:
//   HOLD_CYCLES  cycles each word is held on the bus (1..15)
//   IDLE_ADDR    reserved address parked on the bus between words
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous active-low reset
//   start        in   begin a load (only honoured while idle)
//   abort        in   abandon the load in progress
//   in_valid     in   stream word valid
//   in_ready     out  sequencer accepts the stream word this cycle
//   in_addr      in   config address ([15:0] tile id, [31:16] module id)
//   in_data      in   config data
//   in_last      in   final word of the load
//   config_addr  out  broadcast configuration address
//   config_data  out  broadcast configuration data
//   busy         out  a load is in progress
//   done         out  one-cycle pulse on normal completion
//   error        out  sticky: a received word carried the idle address
//   word_count   out  words driven in the current/last load (saturating)
//   checksum     out  running XOR of addr^data of driven words
// ----------------------------------------------------------------------------
module config_sequencer
   import config_seq_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 2,
   parameter logic [31:0] IDLE_ADDR   = IDLE_ADDR_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_data,
   input  logic        in_last,
   output logic [31:0] config_addr,
   output logic [31:0] config_data,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] word_count,
   output logic [31:0] checksum
);

   localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD = HOLD_CNT_W'(HOLD_CYCLES);

   seqState_e   state_q;
   seqState_e   state_d;
   logic [31:0] addr_q;
   logic [31:0] addr_d;
   logic [31:0] data_q;
   logic [31:0] data_d;
   logic        last_q;
   logic        last_d;
   logic        inReady_q;
   logic        inReady_d;
   logic        busy_q;
   logic        busy_d;
   logic        done_q;
   logic        done_d;
   logic        error_q;
   logic        error_d;
   logic [15:0] wordCount_q;
   logic [15:0] wordCount_d;

   logic        startLoad;
   logic        driveEntry;
   logic        setError;
   logic        holdClear;
   logic        holdExpire;

   config_hold_timer u_holdTimer (
      .clk         (clk),
      .reset       (reset),
      .load_i      (driveEntry),
      .clear_i     (holdClear),
      .loadValue_i (HOLD_LOAD),
      .expire_o    (holdExpire)
   );

   // FSM next-state and bus next-value logic. The bus registers double as the
   // capture registers for the current word: the captured address/data are
   // exactly what is driven during DRIVE. Abort is checked first in every busy
   // state so it overrides any handshake or hold expiry in the same cycle.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      data_d     = data_q;
      last_d     = last_q;
      startLoad  = 1'b0;
      driveEntry = 1'b0;
      setError   = 1'b0;
      holdClear  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_FETCH;
               startLoad = 1'b1;
            end
         end
         ST_FETCH: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (in_valid && inReady_q) begin
               if (in_addr == IDLE_ADDR) begin
                  setError = 1'b1;
                  if (in_last) begin
                     state_d = ST_DONE;
                  end
               end else begin
                  state_d    = ST_DRIVE;
                  addr_d     = in_addr;
                  data_d     = in_data;
                  last_d     = in_last;
                  driveEntry = 1'b1;
               end
            end
         end
         ST_DRIVE: begin
            if (abort) begin
               state_d   = ST_IDLE;
               addr_d    = IDLE_ADDR;
               holdClear = 1'b1;
            end else if (holdExpire) begin
               state_d = ST_GAP;
               addr_d  = IDLE_ADDR;
            end
         end
         ST_GAP: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (last_q) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            addr_d  = IDLE_ADDR;
         end
      endcase
   end

   // Status outputs are registered, so they are derived from the state being
   // entered rather than the current one. Counters and the error flag are
   // cleared when a new load starts, not while idling, so the results of the
   // previous load stay readable until software starts another.
   always_comb begin
      inReady_d = (state_d == ST_FETCH);
      busy_d    = (state_d != ST_IDLE);
      done_d    = (state_d == ST_DONE);

      wordCount_d = wordCount_q;
      if (startLoad) begin
         wordCount_d = '0;
      end else if (driveEntry && (wordCount_q != 16'hFFFF)) begin
         wordCount_d = wordCount_q + 16'd1;
      end

      error_d = error_q | setError;
      if (startLoad) begin
         error_d = 1'b0;
      end
   end

   // State and output registers with synchronous active-low reset; the bus
   // parks on the idle address so a reset mid-load never leaves a live word.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         addr_q      <= IDLE_ADDR;
         data_q      <= '0;
         last_q      <= 1'b0;
         inReady_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         wordCount_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         last_q      <= last_d;
         inReady_q   <= inReady_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         wordCount_q <= wordCount_d;
      end
   end

`ifdef CONFIG_SEQ_CHECKSUM_EN
   logic [31:0] checksum_q;
   logic [31:0] checksum_d;

   // Running checksum folds in each word as it enters DRIVE; discarded words
   // never reach DRIVE and therefore never contribute.
   always_comb begin
      checksum_d = checksum_q;
      if (startLoad) begin
         checksum_d = '0;
      end else if (driveEntry) begin
         checksum_d = checksum_q ^ in_addr ^ in_data;
      end
   end

   // Checksum accumulator register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         checksum_q <= '0;
      end else begin
         checksum_q <= checksum_d;
      end
   end

   assign checksum = checksum_q;
`else
   assign checksum = '0;
`endif

   assign in_ready    = inReady_q;
   assign config_addr = addr_q;
   assign config_data = data_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign error       = error_q;
   assign word_count  = wordCount_q;

endmodule
